// File: rtl/bypass_hazard_unit.sv
// Forwarding and hazard control for the 5-stage pipeline: DX operand-select
// generation, load-use / disabled-bypass / mult-div stall detection, and a
// single-entry scoreboard tracking one in-flight mult/div result.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no mult/div in flight; a dx_md_start latches the tag
// S_BUSY | mult/div in flight; counting down, md_done while count is 0
module bypass_hazard_unit #(
    parameter int REG_BITS   = 5,
    parameter int MD_LATENCY = 32,
    parameter int CNT_WIDTH  = 32,
    parameter int BYPASS_MX  = 1,
    parameter int BYPASS_WX  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [REG_BITS-1:0]  fd_ra,
    input  logic [REG_BITS-1:0]  fd_rb,
    input  logic                 fd_uses_ra,
    input  logic                 fd_uses_rb,
    input  logic [REG_BITS-1:0]  fd_rd,
    input  logic                 fd_we,
    input  logic                 fd_is_md,
    input  logic [REG_BITS-1:0]  dx_ra,
    input  logic [REG_BITS-1:0]  dx_rb,
    input  logic [REG_BITS-1:0]  dx_rd,
    input  logic                 dx_we,
    input  logic                 dx_is_load,
    input  logic                 dx_md_start,
    input  logic [REG_BITS-1:0]  xm_rd,
    input  logic                 xm_we,
    input  logic [REG_BITS-1:0]  mw_rd,
    input  logic                 mw_we,
    output logic [1:0]           sel_a,
    output logic [1:0]           sel_b,
    output logic                 stall,
    output logic                 md_busy,
    output logic [REG_BITS-1:0]  md_rd,
    output logic                 md_done,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam int CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MD_LATENCY - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_t;

    md_state_t             state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [REG_BITS-1:0]   md_rd_q, md_rd_d;

    logic xm_a, xm_b, mw_a, mw_b;
    logic load_use, byp_stall, md_raw, md_struct;
    logic tag_valid;
    logic [REG_BITS-1:0] tag;

    // Producer matches; register 0 never counts as a producer target.
    always_comb begin
        xm_a = xm_we && (xm_rd == dx_ra) && (dx_ra != '0);
        xm_b = xm_we && (xm_rd == dx_rb) && (dx_rb != '0);
        mw_a = mw_we && (mw_rd == dx_ra) && (dx_ra != '0);
        mw_b = mw_we && (mw_rd == dx_rb) && (dx_rb != '0);
    end

    // Operand selects: XM wins over MW since it holds the younger value.
    always_comb begin
        sel_a = 2'b00;
        sel_b = 2'b00;
        if (xm_a && (BYPASS_MX != 0))      sel_a = 2'b01;
        else if (mw_a && (BYPASS_WX != 0)) sel_a = 2'b10;
        if (xm_b && (BYPASS_MX != 0))      sel_b = 2'b01;
        else if (mw_b && (BYPASS_WX != 0)) sel_b = 2'b10;
    end

    // Stall sources; the pending tag comes from the scoreboard while busy,
    // otherwise from DX in the cycle a mult/div issues.
    always_comb begin
        tag_valid = 1'b0;
        tag       = '0;
        if (state_q == S_BUSY) begin
            tag_valid = 1'b1;
            tag       = md_rd_q;
        end else if (dx_md_start) begin
            tag_valid = 1'b1;
            tag       = dx_rd;
        end
        load_use  = dx_is_load && dx_we && (dx_rd != '0) &&
                    ((fd_uses_ra && (fd_ra == dx_rd)) ||
                     (fd_uses_rb && (fd_rb == dx_rd)));
        byp_stall = ((BYPASS_MX == 0) && (xm_a || xm_b)) ||
                    ((BYPASS_WX == 0) && (mw_a || mw_b));
        md_raw    = tag_valid && (tag != '0) &&
                    ((fd_uses_ra && (fd_ra == tag)) ||
                     (fd_uses_rb && (fd_rb == tag)) ||
                     (fd_we && (fd_rd == tag)));
        md_struct = fd_is_md && ((state_q == S_BUSY) || dx_md_start);
        stall     = load_use || byp_stall || md_raw || md_struct;
    end

    // Scoreboard next state; a start while busy is ignored.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        md_rd_d = md_rd_q;
        case (state_q)
            S_IDLE: begin
                if (dx_md_start) begin
                    state_d = S_BUSY;
                    md_rd_d = dx_rd;
                    count_d = CNT_LOAD;
                end
            end
            S_BUSY: begin
                if (count_q == '0) state_d = S_IDLE;
                else               count_d = count_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scoreboard registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            md_rd_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            md_rd_q <= md_rd_d;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clock) begin
        if (!reset)
            stall_count <= '0;
        else if (stall && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
    end

    assign md_busy = (state_q == S_BUSY);
    assign md_done = (state_q == S_BUSY) && (count_q == '0);
    assign md_rd   = md_rd_q;

endmodule

// File: tb/tb_bypass_hazard_unit.sv
// Bench for bypass_hazard_unit: a main instance (MD_LATENCY=4, CNT_WIDTH=4,
// both bypasses on) and a second instance with the XM bypass disabled.
module tb_bypass_hazard_unit;

    localparam int RB = 5;
    localparam int CW = 4;

    localparam int S_SEL_A  = 0;
    localparam int S_SEL_B  = 1;
    localparam int S_STALL  = 2;
    localparam int S_BUSY   = 3;
    localparam int S_DONE   = 4;
    localparam int S_MDRD   = 5;
    localparam int S_CNT    = 6;
    localparam int N_SEL_A  = 7;
    localparam int N_STALL  = 8;

    typedef struct {
        string       tag;
        int          sig;
        int unsigned exp;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic [RB-1:0] fd_ra, fd_rb, fd_rd, dx_ra, dx_rb, dx_rd, xm_rd, mw_rd;
    logic fd_uses_ra, fd_uses_rb, fd_we, fd_is_md;
    logic dx_we, dx_is_load, dx_md_start, xm_we, mw_we;

    logic [1:0]    sel_a, sel_b, n_sel_a, n_sel_b;
    logic          stall, md_busy, md_done, n_stall, n_busy, n_done;
    logic [RB-1:0] md_rd, n_md_rd;
    logic [CW-1:0] stall_count, n_stall_count;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned cnt_model = 0;
    bit          exp_stall_cur = 0;

    always #5 clock = ~clock;

    bypass_hazard_unit #(.REG_BITS(RB), .MD_LATENCY(4), .CNT_WIDTH(CW),
                         .BYPASS_MX(1), .BYPASS_WX(1)) u_dut (
        .clock(clock), .reset(reset),
        .fd_ra(fd_ra), .fd_rb(fd_rb), .fd_uses_ra(fd_uses_ra), .fd_uses_rb(fd_uses_rb),
        .fd_rd(fd_rd), .fd_we(fd_we), .fd_is_md(fd_is_md),
        .dx_ra(dx_ra), .dx_rb(dx_rb), .dx_rd(dx_rd), .dx_we(dx_we),
        .dx_is_load(dx_is_load), .dx_md_start(dx_md_start),
        .xm_rd(xm_rd), .xm_we(xm_we), .mw_rd(mw_rd), .mw_we(mw_we),
        .sel_a(sel_a), .sel_b(sel_b), .stall(stall), .md_busy(md_busy),
        .md_rd(md_rd), .md_done(md_done), .stall_count(stall_count)
    );

    bypass_hazard_unit #(.REG_BITS(RB), .MD_LATENCY(4), .CNT_WIDTH(CW),
                         .BYPASS_MX(0), .BYPASS_WX(1)) u_dut_nomx (
        .clock(clock), .reset(reset),
        .fd_ra(fd_ra), .fd_rb(fd_rb), .fd_uses_ra(fd_uses_ra), .fd_uses_rb(fd_uses_rb),
        .fd_rd(fd_rd), .fd_we(fd_we), .fd_is_md(fd_is_md),
        .dx_ra(dx_ra), .dx_rb(dx_rb), .dx_rd(dx_rd), .dx_we(dx_we),
        .dx_is_load(dx_is_load), .dx_md_start(dx_md_start),
        .xm_rd(xm_rd), .xm_we(xm_we), .mw_rd(mw_rd), .mw_we(mw_we),
        .sel_a(n_sel_a), .sel_b(n_sel_b), .stall(n_stall), .md_busy(n_busy),
        .md_rd(n_md_rd), .md_done(n_done), .stall_count(n_stall_count)
    );

    task automatic chk_val(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned obs_sig(input int sig);
        case (sig)
            S_SEL_A: return 32'(sel_a);
            S_SEL_B: return 32'(sel_b);
            S_STALL: return 32'(stall);
            S_BUSY:  return 32'(md_busy);
            S_DONE:  return 32'(md_done);
            S_MDRD:  return 32'(md_rd);
            S_CNT:   return 32'(stall_count);
            N_SEL_A: return 32'(n_sel_a);
            N_STALL: return 32'(n_stall);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic push(input string tag, input int sig, input int unsigned exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb_q.push_back(e);
        if (sig == S_STALL) exp_stall_cur = (exp != 0);
    endtask

    // Compare everything queued for this cycle, then advance one clock and
    // update the stall-count model from the stall this cycle should have had.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk_val(e.tag, obs_sig(e.sig), e.exp);
        end
        @(posedge clock);
        if (!reset) cnt_model = 0;
        else if (exp_stall_cur && cnt_model < 15) cnt_model++;
        exp_stall_cur = 0;
        #1;
    endtask

    task automatic clear_inputs();
        fd_ra = '0; fd_rb = '0; fd_rd = '0; dx_ra = '0; dx_rb = '0; dx_rd = '0;
        xm_rd = '0; mw_rd = '0;
        fd_uses_ra = 0; fd_uses_rb = 0; fd_we = 0; fd_is_md = 0;
        dx_we = 0; dx_is_load = 0; dx_md_start = 0; xm_we = 0; mw_we = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;

        // post-reset state
        push("rst_busy", S_BUSY, 0);
        push("rst_done", S_DONE, 0);
        push("rst_mdrd", S_MDRD, 0);
        push("rst_cnt", S_CNT, 0);
        push("rst_stall", S_STALL, 0);
        push("rst_sel_a", S_SEL_A, 0);
        tick();

        // double producer on both ports
        xm_we = 1; xm_rd = 5; mw_we = 1; mw_rd = 5; dx_ra = 5; dx_rb = 5;
        push("dbl_sel_a", S_SEL_A, 1);
        push("dbl_sel_b", S_SEL_B, 1);
        push("dbl_stall", S_STALL, 0);
        push("dbl_nomx_sel_a", N_SEL_A, 2);
        push("dbl_nomx_stall", N_STALL, 1);
        tick();
        xm_we = 0;
        push("mw_sel_a", S_SEL_A, 2);
        push("mw_sel_b", S_SEL_B, 2);
        push("mw_stall", S_STALL, 0);
        tick();

        // register zero never bypasses or stalls
        clear_inputs();
        xm_we = 1; xm_rd = 0; dx_ra = 0;
        dx_is_load = 1; dx_we = 1; dx_rd = 0; fd_ra = 0; fd_uses_ra = 1;
        push("r0_sel_a", S_SEL_A, 0);
        push("r0_stall", S_STALL, 0);
        tick();

        // load-use on port b, then unused source, then gone
        clear_inputs();
        dx_is_load = 1; dx_we = 1; dx_rd = 7; fd_rb = 7; fd_uses_rb = 1;
        push("lu_stall", S_STALL, 1);
        push("lu_cnt0", S_CNT, cnt_model);
        tick();
        fd_rb = 0; fd_uses_rb = 0; fd_ra = 7; fd_uses_ra = 0;
        push("lu_unused_stall", S_STALL, 0);
        push("lu_cnt1", S_CNT, cnt_model);
        tick();
        clear_inputs();
        push("lu_after_stall", S_STALL, 0);
        tick();

        // mult/div RAW: issue to r9, FD reads r9
        clear_inputs();
        dx_md_start = 1; dx_we = 1; dx_rd = 9; fd_ra = 9; fd_uses_ra = 1;
        push("md_c0_stall", S_STALL, 1);
        push("md_c0_busy", S_BUSY, 0);
        tick();
        dx_md_start = 0; dx_we = 0; dx_rd = 0;
        for (int k = 1; k <= 4; k++) begin
            push($sformatf("md_c%0d_stall", k), S_STALL, 1);
            push($sformatf("md_c%0d_busy", k), S_BUSY, 1);
            push($sformatf("md_c%0d_done", k), S_DONE, (k == 4) ? 1 : 0);
            push($sformatf("md_c%0d_rd", k), S_MDRD, 9);
            tick();
        end
        push("md_c5_stall", S_STALL, 0);
        push("md_c5_busy", S_BUSY, 0);
        push("md_c5_done", S_DONE, 0);
        push("md_c5_cnt", S_CNT, cnt_model);
        tick();

        // structural: second mult/div held in FD until cycle 5
        clear_inputs();
        dx_md_start = 1; dx_rd = 10; dx_we = 1; fd_is_md = 1;
        push("st_c0_stall", S_STALL, 1);
        tick();
        dx_md_start = 0; dx_rd = 0; dx_we = 0;
        for (int k = 1; k <= 4; k++) begin
            push($sformatf("st_c%0d_stall", k), S_STALL, 1);
            tick();
        end
        push("st_c5_stall", S_STALL, 0);
        push("st_c5_busy", S_BUSY, 0);
        tick();

        // held mult/div issues to r11; WAW from FD, then reset mid-operation
        clear_inputs();
        dx_md_start = 1; dx_rd = 11; dx_we = 1;
        push("rm_c0_busy", S_BUSY, 0);
        push("rm_c0_stall", S_STALL, 0);
        tick();
        clear_inputs();
        fd_we = 1; fd_rd = 11;
        push("waw_stall", S_STALL, 1);
        push("rm_c1_busy", S_BUSY, 1);
        push("rm_c1_rd", S_MDRD, 11);
        push("rm_c1_cnt", S_CNT, cnt_model);
        tick();
        clear_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        fd_ra = 11; fd_uses_ra = 1;
        push("rm_busy", S_BUSY, 0);
        push("rm_rd", S_MDRD, 0);
        push("rm_cnt", S_CNT, 0);
        push("rm_stall", S_STALL, 0);
        tick();

        // disabled XM bypass on the second instance
        clear_inputs();
        xm_we = 1; xm_rd = 3; dx_ra = 3;
        push("nomx_stall", N_STALL, 1);
        push("nomx_sel_a", N_SEL_A, 0);
        push("mx_sel_a", S_SEL_A, 1);
        push("mx_stall", S_STALL, 0);
        tick();
        xm_we = 0; mw_we = 1; mw_rd = 3;
        push("nomx_mw_sel_a", N_SEL_A, 2);
        push("nomx_mw_stall", N_STALL, 0);
        tick();

        // saturation: stall held for 2^4+3 cycles
        clear_inputs();
        dx_is_load = 1; dx_we = 1; dx_rd = 7; fd_ra = 7; fd_uses_ra = 1;
        for (int k = 0; k < 19; k++) begin
            push($sformatf("sat_cnt_%0d", k), S_CNT, cnt_model);
            push($sformatf("sat_stall_%0d", k), S_STALL, 1);
            tick();
        end
        clear_inputs();
        push("sat_final", S_CNT, 15);
        push("sat_final_stall", S_STALL, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bypass_hazard_unit.md
# bypass_hazard_unit

Parametrised forwarding and hazard-control unit for the 5-stage pipeline. It generalises the single writeback-to-execute (W→X) bypass check into three things: full M→X/W→X operand-select generation, load-use stall detection, and a scoreboard that tracks one in-flight multi-cycle mult/div result. It sits beside the pipeline latches, receives decoded register fields from FD/DX/XM/MW, and drives the DX operand muxes plus the pipeline-wide stall.

## Interface
- `REG_BITS`, 5: register-index width.
- `MD_LATENCY`, 32: cycles from mult/div issue in DX to result ready; must be ≥2.
- `CNT_WIDTH`, 32: width of the stall performance counter.
- `BYPASS_MX`, 1: 1 enables the XM→DX path; 0 forces those hazards to stall instead.
- `BYPASS_WX`, 1: 1 enables the MW→DX path; 0 forces those hazards to stall instead.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clock`.
- `fd_ra`, `fd_rb`  in  REG_BITS  source registers of the FD instruction.
- `fd_uses_ra`, `fd_uses_rb`  in  1  the FD instruction actually reads the corresponding source.
- `fd_rd`  in  REG_BITS  destination of the FD instruction; `fd_we`  in  1  it writes.
- `fd_is_md`  in  1  the FD instruction is a mult/div.
- `dx_ra`, `dx_rb`  in  REG_BITS  sources of the DX instruction.
- `dx_rd`  in  REG_BITS; `dx_we`, `dx_is_load`, `dx_md_start`  in  1  DX destination, write enable, load flag, and mult/div issue.
- `xm_rd`  in  REG_BITS; `xm_we`  in  1  XM destination. The jal→r31 and setx→r30 remaps are already resolved upstream.
- `mw_rd`  in  REG_BITS; `mw_we`  in  1  MW destination, same remapping already applied.
- `sel_a`, `sel_b`  out  2  DX operand select: 00 = regfile, 01 = XM result, 10 = MW result. Code 11 is never produced.
- `stall`  out  1  freeze PC and FD, inject a bubble into DX.
- `md_busy`  out  1; `md_rd`  out  REG_BITS; `md_done`  out  1  scoreboard state.
- `stall_count`  out  CNT_WIDTH  saturating count of cycles with `stall`=1.

## Operation
- **Match rule.** A stage is a producer for register r when its `we`=1, its `rd`=r, and r≠0. Register 0 never matches, never bypasses and never stalls.
- **Bypass selection (combinational).** For each of `sel_a` and `sel_b`:
  - If the XM stage is a producer and `BYPASS_MX`=1, select 01. XM has priority because it is the younger producer.
  - Otherwise, if the MW stage is a producer and `BYPASS_WX`=1, select 10.
  - Otherwise select 00.
- **Stall sources (combinational OR).**
  - Load-use: `dx_is_load`, DX is a producer, and DX rd equals an FD source whose `fd_uses_*`=1.
  - Disabled bypass: the DX instruction has a producer in XM (when `BYPASS_MX`=0) or in MW (when `BYPASS_WX`=0).
  - Mult/div RAW/WAW: a pending tag exists and either an FD source in use equals the tag (tag≠0), or `fd_we` is set with `fd_rd`=tag (tag≠0). The pending tag is either the registered `md_rd` while `md_busy`=1, or `dx_rd` in the cycle `dx_md_start`=1.
  - Mult/div structural: `fd_is_md` while `md_busy`=1 or `dx_md_start`=1.
- **Scoreboard states.** Two states, IDLE and BUSY, with a down-counter of width clog2(MD_LATENCY).
  - IDLE→BUSY on `dx_md_start`. Latch `md_rd`←`dx_rd` and load count←MD_LATENCY−1.
  - In BUSY, decrement each cycle. `md_done`=1 combinationally while count=0. BUSY→IDLE on the edge after `md_done`.
  - A `dx_md_start` while BUSY is a protocol violation: it is ignored and the tag is unchanged.
- **Stall counter.** `stall_count` increments on every edge with `stall`=1 and saturates at all-ones.
- **Reset.** While `reset`=0 at an edge: scoreboard goes to IDLE, count→0, `md_rd`→0, `stall_count`→0. This applies even mid-operation and discards any pending mult/div.

## Timing
- `sel_a`, `sel_b` and `stall` are purely combinational, with zero latency.
- With `dx_md_start` in cycle t:
  - `md_busy`=1 in cycles t+1 … t+MD_LATENCY.
  - `md_done`=1 only in cycle t+MD_LATENCY.
  - `md_busy`=0 from t+MD_LATENCY+1.
- A dependent FD instruction stalls from cycle t through t+MD_LATENCY inclusive and advances at t+MD_LATENCY+1. The pipeline writes the mult/div result to the regfile on the `md_done` edge.
- The earliest next mult/div enters DX at t+MD_LATENCY+1.
- Post-reset outputs: `md_busy`=0, `md_done`=0, `md_rd`=0, `stall_count`=0. `stall` and `sel_*` are then functions of the inputs only.

## Test plan
- **Double producer.** XM and MW both write r5 and DX reads r5 on both ports → `sel_a`=`sel_b`=01, `stall`=0. Drop `xm_we` → both selects become 10.
- **Register zero.** XM writes r0 and DX reads r0 → `sel_a`=00. A load to r0 with FD reading r0 → `stall`=0.
- **Load-use.** `dx_is_load` with rd=r7 and FD `fd_ra`=r7 (used) → `stall`=1 for exactly one cycle. `stall_count` goes 0→1.
- **Mult/div latency (`MD_LATENCY`=4).**
  - Issue md to r9 at cycle 0, FD reads r9 → `stall`=1 in cycles 0–4, `md_done`=1 at cycle 4, `md_busy`=0 at cycle 5.
  - A second md in FD is held until cycle 5.
- **Disabled bypass (`BYPASS_MX`=0).** XM writes r3 and DX reads r3 → `stall`=1 and `sel_a`≠01. The following cycle, with the producer now in MW → `sel_a`=10.
- **Reset mid-operation.** Assert `reset`=0 at cycle 2 of a pending md → next cycle `md_busy`=0, `md_rd`=0, `stall_count`=0, and an FD reader of the old tag sees no stall. Separately, force `stall`=1 for 2^CNT_WIDTH+3 cycles with `CNT_WIDTH`=4 → `stall_count` saturates at 15.
